moving_average_filter: RTL and testbench
========================================

MOVING_AVERAGE_FILTER -- requirements
Module: moving_average_filter

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits.
REQ-002 Parameter MAX_WIN, default 16, depth of the sample history buffer; it SHALL be a power of two.
REQ-003 Port clk, input, 1 bit: single clock; all logic SHALL be on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: in_data is a new sample this cycle.
REQ-006 Port in_data, input, DATA_W bits: unsigned sample (the noise generator's rand_out).
REQ-007 Port win_sel, input, 2 bits: window length N; 00=2, 01=4, 10=8, 11=16.
REQ-008 Port out_valid, output, 1 bit: single-cycle pulse marking a new avg_out.
REQ-009 Port avg_out, output, DATA_W bits: windowed mean, unsigned, truncated.
REQ-010 Port win_full, output, 1 bit: at least N samples have been accepted since the last flush.

Function
REQ-011 The block SHALL accept a sample only when in_valid=1; the input has no backpressure, and every valid sample SHALL be consumed.
REQ-012 Accepted samples SHALL be written to a MAX_WIN-entry circular buffer at wr_ptr; wr_ptr SHALL then increment modulo MAX_WIN.
REQ-013 The running sum width SHALL be DATA_W+log2(MAX_WIN) bits (12 at defaults); the sum SHALL never overflow or saturate.
REQ-014 On an accepted sample, the sum SHALL update as sum + in_data - old, where old = buf[(wr_ptr - N) mod MAX_WIN] when fill_cnt >= N, and old = 0 otherwise.
REQ-015 fill_cnt SHALL count accepted samples since the last flush and SHALL saturate at MAX_WIN.
REQ-016 avg_out SHALL equal the updated sum shifted right by log2(N), with the upper bits dropped to DATA_W.
REQ-017 During fill, the shift SHALL still be by log2(N), so missing samples act as zero (ramp-up behaviour).
REQ-018 Latency: out_valid and avg_out SHALL be registered 1 cycle after the accepting in_valid cycle.
REQ-019 avg_out SHALL hold its value between out_valid pulses.
REQ-020 Back-to-back in_valid SHALL yield back-to-back out_valid pulses (throughput 1 sample per cycle).
REQ-021 Control state machine states:
- FILL: fill_cnt < N; win_full=0.
- RUN: fill_cnt >= N; win_full=1.
REQ-022 Transition FILL->RUN SHALL occur on the sample that makes fill_cnt reach N; win_full SHALL assert in the same cycle as that sample's out_valid.
REQ-023 win_sel SHALL be registered into win_q each cycle.
REQ-024 When win_sel differs from win_q, the block SHALL flush:
- sum=0, fill_cnt=0, state=FILL.
- Buffer contents and wr_ptr are not cleared.
REQ-025 If a flush coincides with in_valid=1, that sample SHALL be processed as the first sample of the new window, using the new N.
REQ-026 Buffer wrap-around SHALL be seamless: sample MAX_WIN+1 overwrites entry 0 with no gap in output.

Reset
REQ-027 While rst=1 the following SHALL hold:
- sum=0, fill_cnt=0, wr_ptr=0, state=FILL.
- out_valid=0, avg_out=0, win_full=0.
- win_q loads win_sel.
- Any in_valid is ignored.
REQ-028 Buffer storage SHALL NOT require reset; correctness relies on fill_cnt gating (REQ-014).
REQ-029 A reset asserted mid-stream SHALL discard all history; the first post-reset output SHALL reflect only post-reset samples.

Structure
REQ-030 DATA_W and MAX_WIN defaults, the win_sel encodings and the FILL/RUN state enum SHALL live in the shared filter package (filter_pkg), also used by the noise generator bench.
REQ-031 The history buffer SHALL be a sub-module, sample_ring_buf: one write port plus one combinational read port addressed by (wr_ptr - N).

Verification
REQ-032 win_sel=01 (N=4), six consecutive samples of 100: avg_out sequence SHALL be 25,50,75,100,100,100; win_full SHALL rise with the 4th output.
REQ-033 win_sel=11 (N=16), twenty samples of 255: sum SHALL peak at 4080 with no overflow; outputs from the 16th onward SHALL be 255.
REQ-034 N=2, in_valid asserted on alternate cycles with samples 10,20,30: outputs SHALL be 5,15,25, each exactly 1 cycle after its input, with avg_out held between pulses.
REQ-035 N=4 in RUN on a constant 80 stream, switch win_sel to 00 together with sample 40: output SHALL be 20 and win_full SHALL be 0; the next sample of 40 SHALL give 40 and win_full=1.
REQ-036 Stream 40 samples through N=8 against a golden model: every output SHALL match, covering two wr_ptr wraps.
REQ-037 Pulse rst mid-stream on a 200-valued stream, then feed 4 at N=2: the first output SHALL be 2, with no contribution from pre-reset data.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared definitions for the filter blocks and their benches.
//   DATA_W_DEF  : default sample width in bits
//   MAX_WIN_DEF : default history depth (power of two)
//   win_sel_e   : encoding of the window-length selector
//   fill_state_e: control states of the moving-average filter
//   win_log2()  : log2 of the window length selected by a win_sel code
package filter_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int MAX_WIN_DEF = 16;

  typedef enum logic [1:0] {
    WIN_2  = 2'b00,
    WIN_4  = 2'b01,
    WIN_8  = 2'b10,
    WIN_16 = 2'b11
  } win_sel_e;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_e;

  function automatic logic [2:0] win_log2(input logic [1:0] sel);
    logic [2:0] r_log;
    case (win_sel_e'(sel))
      WIN_2:   r_log = 3'd1;
      WIN_4:   r_log = 3'd2;
      WIN_8:   r_log = 3'd3;
      default: r_log = 3'd4;
    endcase
    return r_log;
  endfunction

endpackage

// File: rtl/sample_ring_buf.sv
// Sample history storage for the moving-average filter.
// One synchronous write port and one combinational read port; contents
// are never reset (the filter gates stale entries with its fill count).
// Ports:
//   clk       : clock, rising edge
//   i_wr_en   : write i_wr_data at i_wr_addr
//   i_wr_addr : write address
//   i_wr_data : sample to store
//   i_rd_addr : read address
//   o_rd_data : stored sample at i_rd_addr (combinational)
module sample_ring_buf
  import filter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = MAX_WIN_DEF
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DATA_W-1:0]        o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/moving_average_filter.sv
// Windowed moving average of an unsigned sample stream.
// A running sum is updated per accepted sample by adding the new sample and
// subtracting the one leaving the window; the mean is the sum shifted right
// by log2(N). Changing win_sel flushes the window (history RAM is kept).
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : in_data holds a new sample (no backpressure)
//   in_data   : unsigned sample
//   win_sel   : window length, 00=2 01=4 10=8 11=16
//   out_valid : one-cycle pulse, avg_out updated
//   avg_out   : truncated windowed mean, held between pulses
//   win_full  : at least N samples accepted since the last flush
module moving_average_filter
  import filter_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_WIN = MAX_WIN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        win_sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] avg_out,
  output logic              win_full
);

  localparam int PTR_W = $clog2(MAX_WIN);
  localparam int SUM_W = DATA_W + PTR_W;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WIN);

  logic [1:0]        r_win_q;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_fill_cnt;
  logic [SUM_W-1:0]  r_sum;
  fill_state_e       r_state;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_avg;

  fill_state_e       w_state_next;
  logic              w_win_full;
  logic              w_flush;
  logic              w_accept;
  logic [2:0]        w_shift;
  logic [CNT_W-1:0]  w_n;
  logic [CNT_W-1:0]  w_fill_base;
  logic [CNT_W-1:0]  w_fill_next;
  logic [SUM_W-1:0]  w_sum_base;
  logic [SUM_W-1:0]  w_sum_next;
  logic [PTR_W-1:0]  w_rd_addr;
  logic [DATA_W-1:0] w_old_raw;
  logic [DATA_W-1:0] w_old;

  assign w_flush  = (win_sel != r_win_q);
  assign w_accept = in_valid & ~rst;

  // When not flushing win_sel equals r_win_q, so win_sel is always the
  // window in force for this cycle's sample (including the flush sample).
  assign w_shift = win_log2(win_sel);
  assign w_n     = CNT_W'(1) << w_shift;

  // A flush coinciding with a sample starts the new window from empty.
  assign w_fill_base = w_flush ? '0 : r_fill_cnt;
  assign w_sum_base  = w_flush ? '0 : r_sum;

  // Oldest sample in the window sits N slots behind the write pointer;
  // for N == MAX_WIN that is the slot about to be overwritten.
  assign w_rd_addr = r_wr_ptr - PTR_W'(w_n);

  sample_ring_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_WIN)
  ) u_ring (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (in_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_old_raw)
  );

  // Until the window is full the departing slot holds stale data.
  assign w_old       = (w_fill_base >= w_n) ? w_old_raw : '0;
  assign w_sum_next  = w_sum_base + SUM_W'(in_data) - SUM_W'(w_old);
  assign w_fill_next = (w_fill_base == CNT_MAX) ? CNT_MAX : w_fill_base + CNT_W'(1);

  // Datapath registers
  always_ff @(posedge clk) begin
    r_win_q <= win_sel;
    if (rst) begin
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_avg       <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_fill_cnt <= w_fill_next;
        r_sum      <= w_sum_next;
        r_avg      <= DATA_W'(w_sum_next >> w_shift);
      end else if (w_flush) begin
        r_fill_cnt <= '0;
        r_sum      <= '0;
      end
    end
  end

  // Control FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Control FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (in_valid) begin
      w_state_next = (w_fill_next >= w_n) ? ST_RUN : ST_FILL;
    end else if (w_flush) begin
      w_state_next = ST_FILL;
    end
  end

  // Control FSM: outputs
  always_comb begin
    w_win_full = (r_state == ST_RUN);
  end

  assign out_valid = r_out_valid;
  assign avg_out   = r_avg;
  assign win_full  = w_win_full;

endmodule

// File: tb/tb_moving_average_filter.sv
module tb_moving_average_filter;

  localparam int DW = 8;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [1:0]    win_sel;
  logic          out_valid;
  logic [DW-1:0] avg_out;
  logic          win_full;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  moving_average_filter #(.DATA_W(DW), .MAX_WIN(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .win_sel   (win_sel),
    .out_valid (out_valid),
    .avg_out   (avg_out),
    .win_full  (win_full)
  );

  // Reference model: list of samples accepted since the last flush/reset;
  // the mean is the sum of the newest N of them divided by N.
  int         m_hist[$];
  logic [1:0] m_sel;
  int         m_avg;
  bit         e_ov;
  int         e_av;
  bit         e_full;

  task automatic model(input bit r, input bit v, input int d, input logic [1:0] s);
    int n;
    int sum;
    n = 2 << int'(s);
    if (r) begin
      m_hist.delete();
      m_sel = s;
      m_avg = 0;
      e_ov = 0; e_av = 0; e_full = 0;
      return;
    end
    if (s != m_sel) m_hist.delete();
    m_sel = s;
    if (v) begin
      m_hist.push_back(d);
      if (m_hist.size() > MW) void'(m_hist.pop_front());
      sum = 0;
      for (int i = 0; i < n && i < m_hist.size(); i++) sum += m_hist[m_hist.size() - 1 - i];
      m_avg = (sum / n) % 256;
    end
    e_ov   = v;
    e_av   = m_avg;
    e_full = (m_hist.size() >= n);
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] d, input logic [1:0] s);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; win_sel = s;
    model(r, v, int'(d), s);
    @(posedge clk);
    #1;
    $display("txn rst=%0d v=%0d d=%0d sel=%0d -> ov=%0d avg=%0d full=%0d",
             r, v, d, s, out_valid, avg_out, win_full);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out_valid"}, int'(out_valid), int'(e_ov));
    chk({tag, ".avg_out"},   int'(avg_out),   e_av);
    chk({tag, ".win_full"},  int'(win_full),  int'(e_full));
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    logic [1:0] s;
    bit         ov;
    logic [7:0] av;
    bit         full;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; win_sel = 2'b01;
    m_sel = 2'b01; m_avg = 0;

    // Directed vectors, applied straight after reset with win_sel=01
    // N=4, six samples of 100
    tbl.push_back('{1'b1, 8'd100, 2'b01, 1'b1, 8'd25,  1'b0});
    tbl.push_back('{1'b1, 8'd100, 2'b01, 1'b1, 8'd50,  1'b0});
    tbl.push_back('{1'b1, 8'd100, 2'b01, 1'b1, 8'd75,  1'b0});
    tbl.push_back('{1'b1, 8'd100, 2'b01, 1'b1, 8'd100, 1'b1});
    tbl.push_back('{1'b1, 8'd100, 2'b01, 1'b1, 8'd100, 1'b1});
    tbl.push_back('{1'b1, 8'd100, 2'b01, 1'b1, 8'd100, 1'b1});
    // N=2, alternate-cycle samples 10,20,30 with hold between pulses
    tbl.push_back('{1'b1, 8'd10,  2'b00, 1'b1, 8'd5,   1'b0});
    tbl.push_back('{1'b0, 8'd0,   2'b00, 1'b0, 8'd5,   1'b0});
    tbl.push_back('{1'b1, 8'd20,  2'b00, 1'b1, 8'd15,  1'b1});
    tbl.push_back('{1'b0, 8'd0,   2'b00, 1'b0, 8'd15,  1'b1});
    tbl.push_back('{1'b1, 8'd30,  2'b00, 1'b1, 8'd25,  1'b1});
    tbl.push_back('{1'b0, 8'd0,   2'b00, 1'b0, 8'd25,  1'b1});
    // N=4 on constant 80, then switch to N=2 together with sample 40
    tbl.push_back('{1'b1, 8'd80,  2'b01, 1'b1, 8'd20,  1'b0});
    tbl.push_back('{1'b1, 8'd80,  2'b01, 1'b1, 8'd40,  1'b0});
    tbl.push_back('{1'b1, 8'd80,  2'b01, 1'b1, 8'd60,  1'b0});
    tbl.push_back('{1'b1, 8'd80,  2'b01, 1'b1, 8'd80,  1'b1});
    tbl.push_back('{1'b1, 8'd80,  2'b01, 1'b1, 8'd80,  1'b1});
    tbl.push_back('{1'b1, 8'd40,  2'b00, 1'b1, 8'd20,  1'b0});
    tbl.push_back('{1'b1, 8'd40,  2'b00, 1'b1, 8'd40,  1'b1});

    // Reset with in_valid asserted: the sample must be ignored
    step(1'b1, 1'b1, 8'd99, 2'b01);
    step(1'b1, 1'b1, 8'd99, 2'b01);
    chk("reset.out_valid", int'(out_valid), 0);
    chk("reset.avg_out",   int'(avg_out),   0);
    chk("reset.win_full",  int'(win_full),  0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0, tbl[i].v, tbl[i].d, tbl[i].s);
      chk($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(tbl[i].ov));
      chk($sformatf("vec%0d.avg_out", i),   int'(avg_out),   int'(tbl[i].av));
      chk($sformatf("vec%0d.win_full", i),  int'(win_full),  int'(tbl[i].full));
    end

    // N=16, twenty samples of 255: ramp then saturated mean 255
    for (int i = 1; i <= 20; i++) begin
      int k;
      k = (i < 16) ? i : 16;
      step(1'b0, 1'b1, 8'd255, 2'b11);
      chk($sformatf("n16_%0d.avg_out", i),  int'(avg_out),  (k * 255) / 16);
      chk($sformatf("n16_%0d.win_full", i), int'(win_full), (i >= 16) ? 1 : 0);
    end

    // Mid-stream reset on a 200 stream, then a single 4 at N=2
    step(1'b0, 1'b1, 8'd200, 2'b00);
    chk("pre_rst0.avg_out", int'(avg_out), 100);
    step(1'b0, 1'b1, 8'd200, 2'b00);
    step(1'b0, 1'b1, 8'd200, 2'b00);
    chk("pre_rst2.avg_out", int'(avg_out), 200);
    step(1'b1, 1'b1, 8'd200, 2'b00);
    chk("mid_rst.out_valid", int'(out_valid), 0);
    chk("mid_rst.avg_out",   int'(avg_out),   0);
    step(1'b0, 1'b1, 8'd4, 2'b00);
    chk("post_rst.out_valid", int'(out_valid), 1);
    chk("post_rst.avg_out",   int'(avg_out),   2);
    chk("post_rst.win_full",  int'(win_full),  0);

    // N=8, 40 back-to-back random samples (two pointer wraps)
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 8'($urandom), 2'b10);
      chk_model($sformatf("n8_%0d", i));
    end

    // Random traffic: gaps, window switches and occasional resets
    begin
      logic [1:0] sel;
      sel = 2'b10;
      for (int i = 0; i < 400; i++) begin
        bit r;
        bit v;
        r = ($urandom_range(0, 99) == 0);
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 29) == 0) sel = 2'($urandom);
        step(r, v, 8'($urandom), sel);
        chk_model($sformatf("rnd%0d", i));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
